// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter merging instruction-fetch (m0) and load/store (m1)
// onto a single bus slave; the granted master is forwarded combinationally.
module bus_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic [31:0] m0_address,
    input  logic [3:0]  m0_wstrobe,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_address,
    input  logic [3:0]  m1_wstrobe,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [31:0] s_address,
    output logic [3:0]  s_wstrobe,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        last_reg, last_next;

    logic [1:0]  req_valid;
    logic [31:0] req_address [2];
    logic [3:0]  req_wstrobe [2];
    logic [31:0] req_wdata   [2];
    logic [1:0]  req_ready;

    logic        grant_active;
    logic        grant_idx;
    logic        other_idx;

    assign req_valid      = {m1_valid, m0_valid};
    assign req_address[0] = m0_address;
    assign req_address[1] = m1_address;
    assign req_wstrobe[0] = m0_wstrobe;
    assign req_wstrobe[1] = m1_wstrobe;
    assign req_wdata[0]   = m0_wdata;
    assign req_wdata[1]   = m1_wdata;

    assign grant_active = (state_reg != IDLE);
    assign grant_idx    = (state_reg == GRANT1);
    assign other_idx    = ~grant_idx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        s_valid    = 1'b0;
        s_address  = '0;
        s_wstrobe  = '0;
        s_wdata    = '0;

        case (state_reg)
            IDLE: begin
                // On a tie the master that did not complete last goes first.
                if (&req_valid)
                    state_next = last_reg ? GRANT0 : GRANT1;
                else if (req_valid[0])
                    state_next = GRANT0;
                else if (req_valid[1])
                    state_next = GRANT1;
            end
            GRANT0, GRANT1: begin
                s_valid   = req_valid[grant_idx];
                s_address = req_address[grant_idx];
                s_wstrobe = req_wstrobe[grant_idx];
                s_wdata   = req_wdata[grant_idx];
                if (req_valid[grant_idx] && s_ready) begin
                    // Hand over directly on completion so contention leaves no bubble.
                    last_next = grant_idx;
                    if (req_valid[other_idx])
                        state_next = other_idx ? GRANT1 : GRANT0;
                    else
                        state_next = IDLE;
                end else if (!req_valid[grant_idx]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = grant_active && (grant_idx == 1'(gi)) && s_ready;
        end
    endgenerate

    assign m0_ready = req_ready[0];
    assign m1_ready = req_ready[1];
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: RAM-like slave, behavioural arbitration/memory model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_address, m1_address;
    logic [3:0]  m0_wstrobe, m1_wstrobe;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_address;
    logic [3:0]  s_wstrobe;
    logic [31:0] s_wdata;
    logic        s_ready;
    logic [31:0] s_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_address(m0_address), .m0_wstrobe(m0_wstrobe),
        .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_address(m1_address), .m1_wstrobe(m1_wstrobe),
        .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_address(s_address), .s_wstrobe(s_wstrobe),
        .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata)
    );

    // Slave: writes complete in the request cycle, reads take a second cycle
    // with registered data. Reset reloads the RAM with a known pattern.
    logic [31:0] ram [16];
    logic        rd_pend_reg;
    logic [31:0] rdata_reg;
    wire         s_read = (s_wstrobe == 4'h0);

    assign s_ready = s_valid && (!s_read || rd_pend_reg);
    assign s_rdata = rdata_reg;

    always @(posedge clk) begin
        if (s_valid && s_read)
            rdata_reg <= ram[s_address[5:2]];
        if (!reset) begin
            rd_pend_reg <= 1'b0;
            for (int i = 0; i < 16; i++)
                ram[i] <= 32'h1000_0000 + i;
        end else begin
            rd_pend_reg <= s_valid && s_read && !rd_pend_reg;
            if (s_valid && s_ready && !s_read)
                for (int b = 0; b < 4; b++)
                    if (s_wstrobe[b])
                        ram[s_address[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the bus (-1 = nobody), who completed last,
    // and what the memory must contain.
    int          mdl_owner;
    int          mdl_last;
    logic [31:0] mem_model [16];

    initial begin
        logic        v [2];
        logic [31:0] a [2];
        logic [3:0]  s [2];
        logic [31:0] d [2];
        logic [31:0] wd;
        logic        done;
        int          k;
        mdl_owner = -1;
        mdl_last  = 1;
        forever begin
            @(negedge clk);
            v[0] = m0_valid; a[0] = m0_address; s[0] = m0_wstrobe; d[0] = m0_wdata;
            v[1] = m1_valid; a[1] = m1_address; s[1] = m1_wstrobe; d[1] = m1_wdata;
            k    = (mdl_owner < 0) ? 0 : mdl_owner;
            done = (mdl_owner >= 0) && v[k] && s_ready;

            if (mdl_owner < 0) begin
                chk("s_valid", 32'(s_valid), 32'd0);
                chk("s_address", s_address, 32'd0);
                chk("s_wstrobe", 32'(s_wstrobe), 32'd0);
                chk("s_wdata", s_wdata, 32'd0);
                chk("m0_ready", 32'(m0_ready), 32'd0);
                chk("m1_ready", 32'(m1_ready), 32'd0);
            end else begin
                chk("s_valid", 32'(s_valid), 32'(v[k]));
                chk("s_address", s_address, a[k]);
                chk("s_wstrobe", 32'(s_wstrobe), 32'(s[k]));
                chk("s_wdata", s_wdata, d[k]);
                chk("m0_ready", 32'(m0_ready), (k == 0) ? 32'(s_ready) : 32'd0);
                chk("m1_ready", 32'(m1_ready), (k == 1) ? 32'(s_ready) : 32'd0);
            end
            chk("m0_rdata", m0_rdata, s_rdata);
            chk("m1_rdata", m1_rdata, s_rdata);
            if (done && s[k] == 4'h0)
                chk("read_data", s_rdata, mem_model[a[k][5:2]]);

            if (!reset) begin
                mdl_owner = -1;
                mdl_last  = 1;
                for (int i = 0; i < 16; i++)
                    mem_model[i] = 32'h1000_0000 + i;
            end else if (mdl_owner < 0) begin
                if (v[0] && v[1])     mdl_owner = 1 - mdl_last;
                else if (v[0])        mdl_owner = 0;
                else if (v[1])        mdl_owner = 1;
            end else if (done) begin
                if (s[k] != 4'h0) begin
                    wd = mem_model[a[k][5:2]];
                    for (int b = 0; b < 4; b++)
                        if (s[k][b]) wd[8*b +: 8] = d[k][8*b +: 8];
                    mem_model[a[k][5:2]] = wd;
                end
                mdl_last  = k;
                mdl_owner = v[1-k] ? 1 - k : -1;
            end else if (!v[k]) begin
                mdl_owner = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic v, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        if (m == 0) begin
            m0_valid = v; m0_address = a; m0_wstrobe = s; m0_wdata = d;
        end else begin
            m1_valid = v; m1_address = a; m1_wstrobe = s; m1_wdata = d;
        end
    endtask

    // Issue one transaction from an idle bus; lat counts cycles including the request cycle.
    task automatic do_txn(input int m, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] rd, output int lat);
        logic rdy;
        set_m(m, 1'b1, a, s, d);
        lat = 0;
        rd  = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            rdy = (m == 0) ? m0_ready : m1_ready;
            if (rdy) begin
                lat = c;
                rd  = (m == 0) ? m0_rdata : m1_rdata;
                break;
            end
        end
        if (lat == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL txn_timeout: master %0d got no ready within 20 cycles", m);
        end
        tick();
        set_m(m, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          seen;
        logic        r0, r1;
        logic        got;

        reset = 1'b0;
        set_m(0, 1'b1, 32'h0, 4'h0, 32'h0);
        set_m(1, 1'b1, 32'h4, 4'h0, 32'h0);

        // Both requesting while reset is held: nothing may reach the slave.
        repeat (3) begin
            @(negedge clk);
            chk("rst_s_valid", 32'(s_valid), 32'd0);
            chk("rst_m0_ready", 32'(m0_ready), 32'd0);
            chk("rst_m1_ready", 32'(m1_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Continuous contention: strict alternation starting with m0, no bubbles.
        seen = 0;
        for (int c = 1; c <= 60 && seen < 8; c++) begin
            @(negedge clk);
            if (c == 2) chk("first_grant_addr", s_address, 32'h0);
            if (c >= 2) chk("no_bubble", 32'(s_valid), 32'd1);
            if (m0_ready || m1_ready) begin
                chk("alt_order", 32'(m1_ready), 32'(seen % 2));
                chk("alt_rdata", m1_ready ? m1_rdata : m0_rdata,
                    (seen % 2 == 1) ? 32'h1000_0001 : 32'h1000_0000);
                seen++;
            end
        end
        if (seen < 8) begin
            n_checks++;
            n_fail++;
            $display("FAIL contention_timeout: got %0d completions, needed 8", seen);
        end
        tick();
        set_m(0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_m(1, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        tick();

        // Single write from m1 and read-back through m0.
        do_txn(1, 32'h10, 4'hF, 32'hDEADBEEF, rd, lat);
        chk("wr_latency", 32'(lat), 32'd2);
        do_txn(0, 32'h10, 4'h0, 32'h0, rd, lat);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_data", rd, 32'hDEADBEEF);

        // Byte-lane write.
        do_txn(0, 32'h20, 4'hF, 32'h11223344, rd, lat);
        do_txn(0, 32'h20, 4'h1, 32'h000000AA, rd, lat);
        do_txn(1, 32'h20, 4'h0, 32'h0, rd, lat);
        chk("byte_rd_latency", 32'(lat), 32'd3);
        chk("byte_rd_data", rd, 32'h112233AA);

        // m1 withdraws its read mid-grant; m0 waiting behind it gets served.
        set_m(1, 1'b1, 32'h8, 4'h0, 32'h0);
        @(negedge clk);
        chk("wd_idle", 32'(s_valid), 32'd0);
        @(negedge clk);
        chk("wd_grant", 32'(s_valid), 32'd1);
        chk("wd_grant_addr", s_address, 32'h8);
        chk("wd_no_ready", 32'(m1_ready), 32'd0);
        tick();
        set_m(1, 1'b0, 32'h0, 4'h0, 32'h0);
        set_m(0, 1'b1, 32'hC, 4'h0, 32'h0);
        @(negedge clk);
        chk("wd_no_ready2", 32'(m1_ready), 32'd0);
        @(negedge clk);
        chk("wd_back_idle", 32'(s_valid), 32'd0);
        got = 1'b0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            chk("wd_m1_quiet", 32'(m1_ready), 32'd0);
            if (m0_ready) begin
                got = 1'b1;
                chk("wd_m0_latency", 32'(c), 32'd2);
                chk("wd_m0_rdata", m0_rdata, 32'h1000_0003);
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL wd_timeout: m0 ready missing after withdrawal");
        end
        tick();
        set_m(0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();

        // Reset during the grant cycle of an m0 read drops it without completion.
        set_m(0, 1'b1, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_grant_ready", 32'(m0_ready), 32'd0);
        tick();
        reset = 1'b1;
        set_m(0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("rstmid_s_valid", 32'(s_valid), 32'd0);
        chk("rstmid_m0_ready", 32'(m0_ready), 32'd0);
        tick();
        do_txn(0, 32'h0, 4'h0, 32'h0, rd, lat);
        chk("rstmid_rd_latency", 32'(lat), 32'd3);
        chk("rstmid_rd_data", rd, 32'h1000_0000);

        // Randomized traffic, occasional withdrawals and reset pulses.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            r0 = m0_ready;
            r1 = m1_ready;
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 199) != 0);
            for (int m = 0; m < 2; m++) begin
                logic v, r;
                v = (m == 0) ? m0_valid : m1_valid;
                r = (m == 0) ? r0 : r1;
                if ((v && r && $urandom_range(0, 1) == 1) ||
                    (!v && $urandom_range(0, 9) < 4))
                    set_m(m, 1'b1, {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                          ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0,
                          $urandom);
                else if ((v && r) || (v && $urandom_range(0, 99) == 0))
                    set_m(m, 1'b0, 32'h0, 4'h0, 32'h0);
            end
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
